tmc_rx_fifo_read_ctrl: RTL

//  Avalon-MM slave that sequences pops of the hardware RX FIFO for the Nios II CPU.

---
 rtl/tmc_rx_fifo_read_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tmc_rx_fifo_read_ctrl.sv
// Avalon-MM read sequencer for the RX FIFO: one rdreq per pop, waits out the FIFO
// read latency, holds the word for the CPU, and supports flush, auto-prefetch and IRQ.
module tmc_rx_fifo_read_ctrl #(
   parameter int DATA_W     = 32,
   parameter int USEDW_W    = 10,
   parameter int RD_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         address,
   input  logic               chipselect,
   input  logic               read,
   input  logic               write_n,
   input  logic [31:0]        writedata,
   output logic [31:0]        readdata,
   output logic               fifo_rdreq,
   input  logic [DATA_W-1:0]  fifo_q,
   input  logic               fifo_empty,
   input  logic [USEDW_W-1:0] fifo_usedw,
   output logic               irq
);

   typedef enum logic [2:0] {S_IDLE, S_POP, S_WAIT, S_CAP, S_FLUSH} state_t;

   state_t            state;
   logic [DATA_W-1:0] data_reg;
   logic              valid;
   logic              underflow;
   logic              req_drop;
   logic              auto_en;
   logic              irq_en;
   logic [31:0]       pop_count;

   logic wr;
   logic rd;
   logic ctrl_wr;
   logic count_wr;
   logic data_rd;
   logic pop_stb;
   logic clr_stb;
   logic flush_stb;
   logic unused;

   assign wr        = chipselect & ~write_n;
   assign rd        = chipselect & read;
   assign ctrl_wr   = wr & (address == 2'd2);
   assign count_wr  = wr & (address == 2'd3);
   assign data_rd   = rd & (address == 2'd0);
   assign pop_stb   = ctrl_wr & writedata[0];
   assign clr_stb   = ctrl_wr & writedata[1];
   assign flush_stb = ctrl_wr & writedata[2];
   assign unused    = ^writedata[31:5];

   assign fifo_rdreq = (state == S_POP) | ((state == S_FLUSH) & ~fifo_empty);
   assign irq        = irq_en & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         data_reg  <= '0;
         valid     <= 1'b0;
         underflow <= 1'b0;
         req_drop  <= 1'b0;
         auto_en   <= 1'b0;
         irq_en    <= 1'b0;
         pop_count <= '0;
      end else begin
         if (ctrl_wr) begin
            auto_en <= writedata[3];
            irq_en  <= writedata[4];
         end
         if (count_wr)
            pop_count <= '0;
         else if (fifo_rdreq)
            pop_count <= pop_count + 32'd1;
         if (data_rd)
            valid <= 1'b0;
         if (clr_stb) begin
            underflow <= 1'b0;
            req_drop  <= 1'b0;
         end
         // Sticky sets and the CAP valid set come after the clears so they win.
         if ((state != S_IDLE) && (pop_stb | flush_stb))
            req_drop <= 1'b1;
         case (state)
            S_IDLE: begin
               if (flush_stb) begin
                  state <= S_FLUSH;
                  valid <= 1'b0;
               end else if (pop_stb & fifo_empty) begin
                  underflow <= 1'b1;
               end else if (pop_stb | (auto_en & ~valid & ~fifo_empty)) begin
                  state <= S_POP;
               end
            end
            S_POP:   state <= (RD_LATENCY == 2) ? S_WAIT : S_CAP;
            S_WAIT:  state <= S_CAP;
            S_CAP: begin
               data_reg <= fifo_q;
               valid    <= 1'b1;
               state    <= S_IDLE;
            end
            S_FLUSH: if (fifo_empty) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata[DATA_W-1:0] = data_reg;
         2'd1: begin
            readdata[0]              = valid;
            readdata[1]              = fifo_empty;
            readdata[2]              = (state != S_IDLE);
            readdata[3]              = underflow;
            readdata[4]              = req_drop;
            readdata[16 +: USEDW_W]  = fifo_usedw;
         end
         2'd2: begin
            readdata[3] = auto_en;
            readdata[4] = irq_en;
         end
         default: readdata = pop_count;
      endcase
   end

endmodule
